// File: rtl/seg_scan_driver_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
//   scan_state_t : per-slot FSM state (blanking gap, then digit lit)
//   SEG_OFF      : segment-bus level that lights nothing, for a given polarity
//   DIG_OFF      : digit-enable level that selects no digit, for a given polarity
//   dig_onehot   : active-high one-hot digit select (up to 8 digits)
package seg_disp_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    function automatic logic [7:0] SEG_OFF(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] DIG_OFF(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] dig_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the scan driver.
//   LD      : load strobe, samples SegIn into the shadow buffer
//   SegIn   : digit k pattern at [8k+7:8k]
//   BI_N    : blank, active low; forces all digits off
//   Seg     : shared segment bus
//   Dig     : per-digit enables
//   FrameTC : one-cycle pulse on the last cycle of each frame
// master drives the load/blank side, slave is the driver itself.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      LD;
    logic [8*NUM_DIGITS-1:0]   SegIn;
    logic                      BI_N;
    logic [7:0]                Seg;
    logic [NUM_DIGITS-1:0]     Dig;
    logic                      FrameTC;

    modport master (
        output LD, SegIn, BI_N,
        input  Seg, Dig, FrameTC
    );

    modport slave (
        input  LD, SegIn, BI_N,
        output Seg, Dig, FrameTC
    );
endinterface

// File: rtl/seg_scan_driver_scan_prescaler.sv
// Slot timer for the scan driver: counts SCAN_DIV cycles per digit slot.
//   CP, MRN      : clock (rising edge), async active-low reset
//   blank_end    : high on the last blanking cycle of the slot
//   slot_pre_end : high on the second-to-last cycle of the slot
//   slot_end     : high on the last cycle of the slot
module scan_prescaler #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic CP,
    input  logic MRN,
    output logic blank_end,
    output logic slot_pre_end,
    output logic slot_end
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign blank_end    = (cnt == CW'(BLANK_CYC - 1));
    assign slot_pre_end = (cnt == CW'(SCAN_DIV - 2));
    assign slot_end     = (cnt == CW'(SCAN_DIV - 1));

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-bus multi-digit 7-segment display.
// Each digit slot is BLANK_CYC cycles with every digit off, then the
// remainder of SCAN_DIV cycles with one digit lit. Segment data is double
// buffered: LD fills a shadow copy that is promoted on the frame boundary.
//   CP, MRN : clock (rising edge), async active-low reset
//   bus     : slave side of seg_scan_driver_if (LD/SegIn/BI_N in,
//             Seg/Dig/FrameTC out, all outputs registered)
module seg_scan_driver
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYC      = 8,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic               CP,
    input  logic               MRN,
    seg_scan_driver_if.slave   bus
);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF_LVL = SEG_OFF(SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_LVL = NUM_DIGITS'(DIG_OFF(DIG_ACTIVE_LOW != 0));

    scan_state_t                 state;
    logic [IW-1:0]               idx;
    logic [NUM_DIGITS-1:0][7:0]  shadow;
    logic [NUM_DIGITS-1:0][7:0]  active;
    logic                        pending;

    logic                        blank_end;
    logic                        slot_pre_end;
    logic                        slot_end;

    logic [NUM_DIGITS-1:0]       dig_onehot_hi;
    logic [NUM_DIGITS-1:0]       dig_on;
    logic [7:0]                  seg_on;

    scan_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .CP           (CP),
        .MRN          (MRN),
        .blank_end    (blank_end),
        .slot_pre_end (slot_pre_end),
        .slot_end     (slot_end)
    );

    // Lit-digit levels for the current index; XOR with the off level
    // applies the segment polarity (off level is all-ones when active low).
    always_comb begin
        dig_onehot_hi = NUM_DIGITS'(dig_onehot(3'(idx)));
        dig_on        = (DIG_ACTIVE_LOW != 0) ? ~dig_onehot_hi : dig_onehot_hi;
        seg_on        = active[idx] ^ SEG_OFF_LVL;
    end

    // Scan FSM. Outputs are computed from the next state so Seg/Dig switch
    // on the same edge that enters the new state. FrameTC is set one cycle
    // early so the registered pulse lands on the final S_ON cycle.
    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state       <= S_BLANK;
            idx         <= '0;
            bus.Seg     <= SEG_OFF_LVL;
            bus.Dig     <= DIG_OFF_LVL;
            bus.FrameTC <= 1'b0;
        end else begin
            bus.FrameTC <= slot_pre_end && (idx == IDX_LAST);
            case (state)
                S_BLANK: begin
                    if (blank_end) begin
                        state   <= S_ON;
                        bus.Dig <= bus.BI_N ? dig_on : DIG_OFF_LVL;
                        bus.Seg <= bus.BI_N ? seg_on : SEG_OFF_LVL;
                    end else begin
                        bus.Dig <= DIG_OFF_LVL;
                        bus.Seg <= SEG_OFF_LVL;
                    end
                end
                S_ON: begin
                    if (slot_end) begin
                        state   <= S_BLANK;
                        idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                        bus.Dig <= DIG_OFF_LVL;
                        bus.Seg <= SEG_OFF_LVL;
                    end else begin
                        // Re-evaluated every cycle so BI_N takes effect on the next edge.
                        bus.Dig <= bus.BI_N ? dig_on : DIG_OFF_LVL;
                        bus.Seg <= bus.BI_N ? seg_on : SEG_OFF_LVL;
                    end
                end
            endcase
        end
    end

    // Double buffer. A load on the frame boundary bypasses the shadow so it
    // is not deferred by a whole frame.
    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (bus.LD) begin
                shadow <= bus.SegIn;
            end
            if (bus.FrameTC && bus.LD) begin
                active  <= bus.SegIn;
                pending <= 1'b0;
            end else if (bus.FrameTC && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (bus.LD) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYC=2, active-low digits, active-high segments (32-cycle frame).
module tb_seg_scan_driver;

    logic CP  = 1'b0;
    logic MRN = 1'b0;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned fc    = 0;

    localparam logic [31:0] DAT_A = 32'h6F_4F_5B_06;
    localparam logic [31:0] DAT_B = 32'h7F_07_7D_6D;
    localparam logic [31:0] DAT_C = 32'h3F_66_4F_5B;
    localparam logic [31:0] DAT_D = 32'h71_79_5E_39;
    localparam logic [31:0] DAT_E = 32'h11_22_33_44;

    seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (8),
        .BLANK_CYC      (2),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .CP  (CP),
        .MRN (MRN),
        .bus (bus)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s fc=%0d got=%h exp=%h", tag, fc, got, exp);
        end
    endtask

    // Expected Dig for frame cycle c: slots of 8, first 2 cycles blank.
    function automatic logic [3:0] exp_dig(input int unsigned c, input bit blank);
        int unsigned pos  = c % 8;
        int unsigned slot = c / 8;
        logic [3:0]  oh;
        if (pos < 2 || blank) return 4'hF;
        oh = 4'b0001 << slot;
        return ~oh;
    endfunction

    function automatic logic [7:0] exp_seg(input int unsigned c, input logic [31:0] d, input bit blank);
        int unsigned pos  = c % 8;
        int unsigned slot = c / 8;
        if (pos < 2 || blank) return 8'h00;
        return d[slot*8 +: 8];
    endfunction

    // Check the current cycle, then advance one clock; any LD pulse lasts one cycle.
    task automatic cyc(input logic [31:0] d, input bit blank);
        chk("dig", 32'(bus.Dig), 32'(exp_dig(fc, blank)));
        chk("seg", 32'(bus.Seg), 32'(exp_seg(fc, d, blank)));
        chk("frametc", 32'(bus.FrameTC), (fc == 31) ? 32'd1 : 32'd0);
        @(posedge CP);
        #1;
        fc     = (fc + 1) % 32;
        bus.LD = 1'b0;
    endtask

    initial begin
        bus.LD    = 1'b0;
        bus.SegIn = '0;
        bus.BI_N  = 1'b1;

        // Reset state
        repeat (2) @(posedge CP);
        #1;
        chk("rst_seg", 32'(bus.Seg), 32'h00);
        chk("rst_dig", 32'(bus.Dig), 32'hF);
        chk("rst_ftc", 32'(bus.FrameTC), 32'd0);
        MRN = 1'b1;
        fc  = 0;

        // Frame 0: empty buffer; load A mid-frame, must not appear yet
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 5) begin bus.LD = 1'b1; bus.SegIn = DAT_A; end
            cyc(32'h0, 1'b0);
        end

        // Frame 1: shows A; loads B then C mid-frame (C wins next frame)
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 12) begin bus.LD = 1'b1; bus.SegIn = DAT_B; end
            if (i == 20) begin bus.LD = 1'b1; bus.SegIn = DAT_C; end
            cyc(DAT_A, 1'b0);
        end

        // Frame 2: shows C; E loaded mid-frame, D loaded on the FrameTC cycle
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 8)  begin bus.LD = 1'b1; bus.SegIn = DAT_E; end
            if (i == 31) begin bus.LD = 1'b1; bus.SegIn = DAT_D; end
            cyc(DAT_C, 1'b0);
        end
        chk("pending_clr", 32'(dut.pending), 32'd0);

        // Frame 3: shows D; BI_N low for 10 cycles from fc 10
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 10) bus.BI_N = 1'b0;
            if (i == 20) bus.BI_N = 1'b1;
            cyc(DAT_D, (i >= 11 && i <= 20));
        end

        // Frame 4: reset pulse while digit 2 is lit
        for (int unsigned i = 0; i < 20; i++) begin
            cyc(DAT_D, 1'b0);
        end
        chk("pre_rst_dig", 32'(bus.Dig), 32'hB);
        MRN = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(bus.Seg), 32'h00);
        chk("mid_rst_dig", 32'(bus.Dig), 32'hF);
        chk("mid_rst_ftc", 32'(bus.FrameTC), 32'd0);
        @(posedge CP);
        #1;
        MRN = 1'b1;
        fc  = 0;

        // Frame after reset: restart at digit 0 blank, active buffer cleared
        for (int unsigned i = 0; i < 32; i++) begin
            cyc(32'h0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
